// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write arbiter.
//   lcd_state_e   : arbiter FSM states
//   LCD_CMD_*     : HD44780 commands that need the long post-write delay
//   *_DLY_DEF     : default post-write idle cycle counts at 50 MHz
//   is_slow_cmd() : true for commands that take the long delay
package lcd_pkg;

  localparam int unsigned CNT_W = 17;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int unsigned SHORT_DLY_DEF = 2000;   // 40 us
  localparam int unsigned LONG_DLY_DEF  = 82000;  // 1.64 ms

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StDelay
  } lcd_state_e;

  // 0x03 is also "return home": the controller ignores bit 0 of that command.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == LCD_CMD_CLEAR || data == LCD_CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable 17-bit down-counter used for the post-write idle time.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : count to load
//   dec_i      : decrement by one, saturating at zero
//   expired_o  : high while the count is 0 or 1, i.e. this is the last counted cycle
module lcd_delay_timer
  import lcd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_val_i;
    end else if (dec_i && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  // Flagging at 1 rather than 0 lets a loaded count of N span exactly N cycles.
  assign expired_o = (value_q[CNT_W-1:1] == '0);

endmodule

// File: rtl/lcd_write_arbiter.sv
// Arbitrates two byte-write requesters onto one LCD byte write engine and
// enforces the controller's post-write idle time.
//   iCLK, iRST        : clock, synchronous active-high reset
//   iREQ0/1           : write requests (held until oACK0/1)
//   iRS0/1, iDATA0/1  : register select and byte of each requester
//   oACK0/1           : one-cycle accept pulse, byte latched
//   oRS, oDATA        : latched register select and byte to the engine
//   oSTART            : level start to the engine, dropped when iDONE is accepted
//   iDONE             : level done from the engine (stale-high until it sees start)
//   oBUSY             : high whenever the arbiter is not idle
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned SHORT_DLY = SHORT_DLY_DEF,
  parameter int unsigned LONG_DLY  = LONG_DLY_DEF
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iREQ0,
  input  logic       iREQ1,
  input  logic       iRS0,
  input  logic       iRS1,
  input  logic [7:0] iDATA0,
  input  logic [7:0] iDATA1,
  output logic       oACK0,
  output logic       oACK1,
  output logic       oRS,
  output logic [7:0] oDATA,
  output logic       oSTART,
  input  logic       iDONE,
  output logic       oBUSY
);

  localparam logic [CNT_W-1:0] ShortVal = CNT_W'(SHORT_DLY);
  localparam logic [CNT_W-1:0] LongVal  = CNT_W'(LONG_DLY);

  lcd_state_e state_q;
  logic       last_q;   // requester granted last time
  logic       mask_q;   // first WAIT_DONE cycle: iDONE may still be the stale level
  logic       ack0_q;
  logic       ack1_q;
  logic       rs_q;
  logic [7:0] data_q;
  logic       start_q;

  logic             gnt1;
  logic             done_accept;
  logic             dly_expired;
  logic [CNT_W-1:0] dly_val;

  // Round-robin on a tie: the requester not granted last time wins.
  always_comb begin
    gnt1 = iREQ1;
    if (iREQ0 && iREQ1) begin
      gnt1 = ~last_q;
    end
  end

  assign done_accept = (state_q == StWaitDone) && !mask_q && iDONE;
  assign dly_val     = is_slow_cmd(rs_q, data_q) ? LongVal : ShortVal;

  lcd_delay_timer u_delay_timer (
    .clk_i      (iCLK),
    .rst_i      (iRST),
    .load_i     (done_accept),
    .load_val_i (dly_val),
    .dec_i      (state_q == StDelay),
    .expired_o  (dly_expired)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      mask_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      start_q <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iREQ0 || iREQ1) begin
            state_q <= StIssue;
            start_q <= 1'b1;
            last_q  <= gnt1;
            if (gnt1) begin
              ack1_q <= 1'b1;
              rs_q   <= iRS1;
              data_q <= iDATA1;
            end else begin
              ack0_q <= 1'b1;
              rs_q   <= iRS0;
              data_q <= iDATA0;
            end
          end
        end
        StIssue: begin
          state_q <= StWaitDone;
          mask_q  <= 1'b1;
        end
        StWaitDone: begin
          if (mask_q) begin
            mask_q <= 1'b0;
          end else if (iDONE) begin
            start_q <= 1'b0;
            state_q <= StDelay;
          end
        end
        StDelay: begin
          if (dly_expired) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign oACK0  = ack0_q;
  assign oACK1  = ack1_q;
  assign oRS    = rs_q;
  assign oDATA  = data_q;
  assign oSTART = start_q;
  assign oBUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Randomized bench for lcd_write_arbiter. The reference model works on edge
// timestamps: grant edge g, done-accept edge d >= g+3, idle again after d+N.
module tb_lcd_write_arbiter;

  localparam int unsigned ShortDly  = 12;
  localparam int unsigned LongDly   = 45;
  localparam int          NumCycles = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, rs0, rs1, done;
  logic [7:0] data0, data1;
  logic       ack0, ack1, rs_o, start_o, busy_o;
  logic [7:0] data_o;

  always #5 clk = ~clk;

  lcd_write_arbiter #(
    .SHORT_DLY (ShortDly),
    .LONG_DLY  (LongDly)
  ) dut (
    .iCLK   (clk),
    .iRST   (rst),
    .iREQ0  (req0),
    .iREQ1  (req1),
    .iRS0   (rs0),
    .iRS1   (rs1),
    .iDATA0 (data0),
    .iDATA1 (data1),
    .oACK0  (ack0),
    .oACK1  (ack1),
    .oRS    (rs_o),
    .oDATA  (data_o),
    .oSTART (start_o),
    .iDONE  (done),
    .oBUSY  (busy_o)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;  // index of the most recent clock edge

  // Reference model state
  bit       m_in_write;   // between grant edge and done-accept edge
  int       m_g;          // grant edge of the current write
  int       m_delay_end;  // last edge of the post-write delay
  int       m_lat;        // engine latency chosen for the current write
  bit       m_last;
  bit       m_rs;
  bit [7:0] m_data;
  bit       m_ack0, m_ack1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic int delay_for(input bit rs, input bit [7:0] d);
    if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LongDly;
    return ShortDly;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 5))
      0: return 8'h01;
      1: return 8'h02;
      2: return 8'h03;
      3: return 8'h38;
      4: return 8'h41;
      default: return 8'($urandom);
    endcase
  endfunction

  // Apply the rules to the inputs that were present at edge t.
  task automatic model_step();
    bit pick1;
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (rst) begin
      m_in_write  = 1'b0;
      m_delay_end = t;
      m_last      = 1'b1;
      m_rs        = 1'b0;
      m_data      = 8'h00;
    end else if (m_in_write) begin
      if (t >= m_g + 3 && done) begin
        m_in_write  = 1'b0;
        m_delay_end = t + delay_for(m_rs, m_data);
      end
    end else if (t > m_delay_end && (req0 || req1)) begin
      if (req0 && req1) pick1 = (m_last == 1'b0);
      else              pick1 = req1;
      m_last     = pick1;
      m_g        = t;
      m_in_write = 1'b1;
      m_lat      = int'($urandom_range(0, 4));
      if (pick1) begin
        m_ack1 = 1'b1;
        m_rs   = rs1;
        m_data = data1;
      end else begin
        m_ack0 = 1'b1;
        m_rs   = rs0;
        m_data = data0;
      end
    end
  endtask

  task automatic next_req(input bit acked, input bit idle_next,
                          inout logic req, inout logic rs, inout logic [7:0] data);
    if (acked) begin
      req = 1'($urandom_range(0, 1));
      if (req) begin
        rs   = 1'($urandom_range(0, 1));
        data = rand_byte();
      end
    end else if (req) begin
      // Withdrawing is only legal while no grant can happen.
      if (!idle_next && $urandom_range(0, 19) == 0) req = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      req  = 1'b1;
      rs   = 1'($urandom_range(0, 1));
      data = rand_byte();
    end
  endtask

  task automatic drive_next();
    int e;
    bit idle_next;
    e         = t + 1;
    idle_next = !m_in_write && (e > m_delay_end);
    rst       = (t < 3) || ($urandom_range(0, 199) == 0);
    if (m_in_write) begin
      // Engine: stale done level right after start, then done after m_lat cycles.
      if (e <= m_g + 2) done = ($urandom_range(0, 3) != 0);
      else              done = (e >= m_g + 3 + m_lat);
    end else begin
      done = 1'($urandom_range(0, 1));
    end
    next_req(m_ack0, idle_next, req0, rs0, data0);
    next_req(m_ack1, idle_next, req1, rs1, data1);
  endtask

  initial begin
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    rs0   = 1'b0;
    rs1   = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    done  = 1'b0;
    m_in_write  = 1'b0;
    m_g         = 0;
    m_delay_end = 0;
    m_lat       = 0;
    m_last      = 1'b1;
    m_rs        = 1'b0;
    m_data      = 8'h00;
    m_ack0      = 1'b0;
    m_ack1      = 1'b0;

    for (int i = 0; i < NumCycles; i++) begin
      @(posedge clk);
      t++;
      model_step();
      #1;
      check_eq("ack0",  32'(ack0),    32'(m_ack0));
      check_eq("ack1",  32'(ack1),    32'(m_ack1));
      check_eq("start", 32'(start_o), 32'(m_in_write));
      check_eq("busy",  32'(busy_o),  32'(m_in_write || (t < m_delay_end)));
      check_eq("rs",    32'(rs_o),    32'(m_rs));
      check_eq("data",  32'(data_o),  32'(m_data));
      drive_next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 SHALL have parameter SHORT_DLY, default 2000, meaning post-write idle cycles for ordinary writes (40 us at 50 MHz).
REQ-002 SHALL have parameter LONG_DLY, default 82000, meaning post-write idle cycles after clear/home commands (1.64 ms).
REQ-003 SHALL have port iCLK  input  1  single clock for all logic.
REQ-004 SHALL have port iRST  input  1  reset; synchronous and active-high.
REQ-005 SHALL have ports iREQ0/iREQ1  input  1 each  write request from requester 0/1.
REQ-006 SHALL have ports iRS0/iRS1  input  1 each  register select from requester 0/1 (0 = command, 1 = data).
REQ-007 SHALL have ports iDATA0/iDATA1  input  8 each  byte from requester 0/1.
REQ-008 SHALL have ports oACK0/oACK1  output  1 each  one-cycle pulse: request accepted, byte latched.
REQ-009 SHALL have port oRS  output  1  latched register select to the byte write engine.
REQ-010 SHALL have port oDATA  output  8  latched byte to the byte write engine.
REQ-011 SHALL have port oSTART  output  1  level start to the byte write engine.
REQ-012 SHALL have port iDONE  input  1  level done from the byte write engine; stays high from the end of a write until the next start is detected.
REQ-013 SHALL have port oBUSY  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT_DONE, DELAY.
REQ-015 IDLE: SHALL sample iREQ0/iREQ1 each cycle; if any is high, it SHALL grant exactly one, latch that requester's iRS/iDATA into oRS/oDATA, and go to ISSUE.
REQ-016 Arbitration SHALL be round-robin: if both requests are high, grant the requester not granted last; the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-017 In ISSUE, oACKk SHALL be high for exactly that cycle and oSTART SHALL rise; both occur one cycle after the granting IDLE edge.
REQ-018 The grant SHALL go to WAIT_DONE after one cycle.
REQ-019 oSTART SHALL stay high from ISSUE until iDONE is accepted in WAIT_DONE, then go low.
REQ-020 WAIT_DONE SHALL ignore iDONE for the first 2 cycles after oSTART rises, to mask the stale done level, and SHALL accept iDONE from the 3rd cycle on.
REQ-021 On accepting iDONE, WAIT_DONE SHALL load the delay counter and go to DELAY.
REQ-022 The delay SHALL be LONG_DLY if oRS = 0 and oDATA is in {0x01, 0x02, 0x03}; otherwise it SHALL be SHORT_DLY.
REQ-023 DELAY SHALL last exactly the loaded count of cycles, then return to IDLE.
REQ-024 The counter SHALL be 17 bits, with no wrap-around; the count SHALL saturate at 0.
REQ-025 oRS/oDATA SHALL remain stable from ISSUE through the end of DELAY.
REQ-026 Requests arriving outside IDLE SHALL be held pending by the requester, with no queuing inside the block.
REQ-027 A request deasserted before its grant SHALL be dropped silently.
REQ-028 A requester SHALL hold iREQ, iRS and iDATA stable until it sees oACK.
REQ-029 A request still high on the cycle after its oACK SHALL be treated as a new request.
REQ-030 Minimum spacing between two oSTART rising edges SHALL be 4 + SHORT_DLY cycles.

Reset
REQ-031 While iRST is high at a clock edge, the block SHALL set state = IDLE, oSTART = 0, oACK0 = oACK1 = 0, oRS = 0, oDATA = 0x00, oBUSY = 0, delay counter = 0, and last-grant pointer = 1.
REQ-032 Reset asserted mid-write or mid-delay SHALL abort immediately, with no ack and no further start; the first grant after release SHALL be possible on the first edge with iRST low.

Structure
REQ-033 Package lcd_pkg SHALL hold the state enum type and the constants LCD_CMD_CLEAR = 0x01, LCD_CMD_HOME = 0x02, SHORT_DLY_DEF and LONG_DLY_DEF.
REQ-034 Sub-module lcd_delay_timer SHALL be a loadable 17-bit down-counter (load, value, expired) with the same clock and reset.

Verification
REQ-035 Single request: iREQ0 = 1, iRS0 = 1, iDATA0 = 0x41 in IDLE; expect oACK0 and oSTART high one cycle later, oDATA = 0x41, oRS = 1, and oSTART low after accepted iDONE; then oBUSY high for SHORT_DLY more cycles.
REQ-036 Tie: iREQ0 = iREQ1 = 1 held after each ack; expect grants in the order 0, 1, 0, 1, with one ack per write.
REQ-037 Clear delay: iRS1 = 0, iDATA1 = 0x01; expect DELAY to last LONG_DLY = 82000 cycles. Repeat with 0x38 and expect 2000 cycles.
REQ-038 Stale done: iDONE held high before the write and low in cycles 1-2 after oSTART, then high; expect oSTART held until the 3rd-cycle done and no early DELAY entry.
REQ-039 Reset mid-operation: assert iRST in WAIT_DONE and in DELAY; expect all outputs at reset values next cycle, and a new request acked one cycle after release.
